// File: rtl/im_loader.sv
// im_loader: host byte-stream loader for the instruction memory.
// Assembles big-endian 32-bit words and writes them at incrementing addresses.
module im_loader #(
    parameter int IMEM_SIZE = 128
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic        WE,
    output logic [31:0] W_Addr,
    output logic [31:0] W_Ins,
    output logic        LOADING,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] WCOUNT
);

    localparam logic [15:0] MAX_N = 16'(IMEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  byte_q;
    logic [23:0] shift_q;

    logic        xfer;
    logic [15:0] len_rx;
    logic [15:0] idx_inc;

    assign xfer    = RX_VALID & RX_READY;
    assign len_rx  = {len_q[15:8], RX_DATA};
    assign idx_inc = idx_q + 16'd1;

    // State register; reset abandons any session in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode driven by START and accepted bytes.
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (START) begin
                    state_n = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    state_n = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_rx == 16'd0) begin
                        state_n = S_DONE;
                    end else if (len_rx > MAX_N) begin
                        state_n = S_ERR;
                    end else begin
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && byte_q == 2'd3) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (idx_inc == len_q) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_DATA;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track it exactly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_READY <= 1'b0;
            WE       <= 1'b0;
            LOADING  <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            RX_READY <= (state_n == S_LEN_HI) ||
                        (state_n == S_LEN_LO) ||
                        (state_n == S_DATA);
            WE       <= (state_n == S_WRITE);
            LOADING  <= (state_n == S_LEN_HI) ||
                        (state_n == S_LEN_LO) ||
                        (state_n == S_DATA)   ||
                        (state_n == S_WRITE);
            DONE     <= (state_n == S_DONE);
            ERR      <= (state_n == S_ERR);
        end
    end

    // Length capture, byte assembly and write-port registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            byte_q  <= 2'd0;
            shift_q <= 24'd0;
            W_Addr  <= 32'd0;
            W_Ins   <= 32'd0;
            WCOUNT  <= 16'd0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (START) begin
                        len_q   <= 16'd0;
                        idx_q   <= 16'd0;
                        byte_q  <= 2'd0;
                        shift_q <= 24'd0;
                        WCOUNT  <= 16'd0;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= RX_DATA;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= RX_DATA;
                        idx_q      <= 16'd0;
                        byte_q     <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        shift_q <= {shift_q[15:0], RX_DATA};
                        byte_q  <= byte_q + 2'd1;
                        // Word registers change only here, so they hold
                        // their last value whenever WE is low.
                        if (byte_q == 2'd3) begin
                            W_Ins  <= {shift_q, RX_DATA};
                            W_Addr <= {14'd0, idx_q, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    idx_q  <= idx_inc;
                    WCOUNT <= WCOUNT + 16'd1;
                    byte_q <= 2'd0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed stream tests with a write scoreboard.
// Expected writes are queued by stimulus and popped by a WE monitor.
module tb_im_loader;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WE;
    logic [31:0] W_Addr;
    logic [31:0] W_Ins;
    logic        LOADING;
    logic        DONE;
    logic        ERR;
    logic [15:0] WCOUNT;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    logic prev_we = 1'b0;

    im_loader #(.IMEM_SIZE(128)) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .WE(WE),
        .W_Addr(W_Addr),
        .W_Ins(W_Ins),
        .LOADING(LOADING),
        .DONE(DONE),
        .ERR(ERR),
        .WCOUNT(WCOUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every WE pulse must match the oldest queued write.
    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            n_cmp++;
            if (prev_we) begin
                n_bad++;
                $display("FAIL we_width: got WE high 2 cycles expected 1");
            end
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_we: got addr %h ins %h expected none",
                         W_Addr, W_Ins);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (W_Addr !== e.a || W_Ins !== e.d) begin
                    n_bad++;
                    $display("FAIL write: got %h/%h expected %h/%h",
                             W_Addr, W_Ins, e.a, e.d);
                end
            end
        end
        prev_we = (WE === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge CLK);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        t = 0;
        while (RX_READY !== 1'b1 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (RX_READY !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got RX_READY %b expected 1", RX_READY);
        end
        @(posedge CLK);
    endtask

    task automatic idle(input int n);
        @(negedge CLK);
        RX_VALID = 1'b0;
        repeat (n) @(posedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_end(input string name, input int maxc);
        int t;
        @(negedge CLK);
        RX_VALID = 1'b0;
        t = 0;
        while (DONE !== 1'b1 && ERR !== 1'b1 && t < maxc) begin
            @(negedge CLK);
            t++;
        end
        if (DONE !== 1'b1 && ERR !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got DONE/ERR 0 expected 1", name);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    initial begin
        logic [31:0] w;
        logic        any_ready;
        RST      = 1'b0;
        START    = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(RX_READY), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_loading", 32'(LOADING), 32'd0);
        chk("rst_done_err", {30'd0, DONE, ERR}, 32'd0);
        chk("rst_addr", W_Addr, 32'd0);
        chk("rst_ins", W_Ins, 32'd0);
        chk("rst_wcount", 32'(WCOUNT), 32'd0);
        RST = 1'b1;

        // Two words, valid held high.
        pulse_start();
        chk("t1_loading", 32'(LOADING), 32'd1);
        push_wr(32'h0, 32'h12345678);
        push_wr(32'h4, 32'h9ABCDEF0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        wait_end("t1", 10);
        chk("t1_done", 32'(DONE), 32'd1);
        chk("t1_err", 32'(ERR), 32'd0);
        chk("t1_loading_end", 32'(LOADING), 32'd0);
        chk("t1_wcount", 32'(WCOUNT), 32'd2);
        chk("t1_queue", exp_q.size(), 32'd0);

        // Empty image.
        pulse_start();
        chk("t2_done_clr", 32'(DONE), 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_end("t2", 2);
        chk("t2_done", 32'(DONE), 32'd1);
        chk("t2_wcount", 32'(WCOUNT), 32'd0);

        // Oversized image.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h81);
        wait_end("t3", 3);
        chk("t3_err", 32'(ERR), 32'd1);
        chk("t3_done", 32'(DONE), 32'd0);
        chk("t3_loading", 32'(LOADING), 32'd0);
        RX_VALID = 1'b1;
        RX_DATA  = 8'h55;
        any_ready = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            any_ready = any_ready | RX_READY;
        end
        chk("t3_no_ready", 32'(any_ready), 32'd0);
        RX_VALID = 1'b0;
        chk("t3_wcount", 32'(WCOUNT), 32'd0);

        // One word with gaps and a stray START.
        pulse_start();
        push_wr(32'h0, 32'hA1B2C3D4);
        send_byte(8'h00);
        idle(3);
        send_byte(8'h01);
        idle(3);
        send_byte(8'hA1);
        idle(3);
        send_byte(8'hB2);
        idle(1);
        pulse_start();
        idle(2);
        send_byte(8'hC3);
        idle(3);
        send_byte(8'hD4);
        wait_end("t4", 10);
        chk("t4_done", 32'(DONE), 32'd1);
        chk("t4_wcount", 32'(WCOUNT), 32'd1);
        chk("t4_queue", exp_q.size(), 32'd0);

        // Asynchronous reset mid-word.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        #2;
        RST = 1'b0;
        #1;
        chk("t5_ready", 32'(RX_READY), 32'd0);
        chk("t5_loading", 32'(LOADING), 32'd0);
        chk("t5_ins", W_Ins, 32'd0);
        chk("t5_wcount", 32'(WCOUNT), 32'd0);
        RX_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t5_idle", {30'd0, LOADING, RX_READY}, 32'd0);
        pulse_start();
        push_wr(32'h0, 32'h55667788);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h55667788);
        wait_end("t5", 10);
        chk("t5_done", 32'(DONE), 32'd1);
        chk("t5_queue", exp_q.size(), 32'd0);

        // Full memory.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h80);
        for (int i = 0; i < 128; i++) begin
            w[31:24] = 8'(4 * i);
            w[23:16] = 8'(4 * i + 1);
            w[15:8]  = 8'(4 * i + 2);
            w[7:0]   = 8'(4 * i + 3);
            push_wr(32'(i) << 2, w);
            send_word(w);
        end
        wait_end("t6", 10);
        chk("t6_done", 32'(DONE), 32'd1);
        chk("t6_err", 32'(ERR), 32'd0);
        chk("t6_wcount", 32'(WCOUNT), 32'd128);
        chk("t6_last_addr", W_Addr, 32'h1FC);
        repeat (3) @(negedge CLK);
        chk("t6_queue", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
